// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the memory burst controller.
package mem_ctrl_pkg;

  localparam int unsigned DefDataWidth  = 32;
  localparam int unsigned DefAddrWidth  = 64;
  localparam int unsigned DefBlockWords = 16;
  localparam int unsigned DefMemLatency = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } op_e;

  // Counter width that stays at least one bit for degenerate ranges.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Burst address generator: latches the block base, steps word and slot counters and
// produces the registered word address plus slot/burst boundary flags.
module burst_addr_gen
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned BLOCK_WORDS = DefBlockWords,
  parameter int unsigned MEM_LATENCY = DefMemLatency
) (
  input  logic                           clk,
  input  logic                           arst,
  input  logic                           start_i,
  input  logic                           wrap_i,
  input  logic                           active_i,
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] widx_o,
  output logic                           slot_last_o,
  output logic                           burst_last_o
);

  localparam int unsigned WidxW = $clog2(BLOCK_WORDS);
  localparam int unsigned LatW  = clog2_min1(MEM_LATENCY);
  localparam int unsigned OffW  = WidxW + 2;

  logic [ADDR_WIDTH-OffW-1:0] base_hi_q, base_hi_d;
  logic [WidxW-1:0]           first_q, first_d;
  logic [WidxW-1:0]           wcnt_q, wcnt_d;
  logic [WidxW-1:0]           widx_next;
  logic [LatW-1:0]            lcnt_q, lcnt_d;
  logic [ADDR_WIDTH-1:0]      mem_addr_q, mem_addr_d;
  logic                       unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];

  // Adding the start word makes the index wrap modulo the block size for free.
  assign widx_o       = first_q + wcnt_q;
  assign widx_next    = widx_o + WidxW'(1);
  assign slot_last_o  = active_i && (lcnt_q == LatW'(MEM_LATENCY - 1));
  assign burst_last_o = slot_last_o && (wcnt_q == WidxW'(BLOCK_WORDS - 1));
  assign mem_addr_o   = mem_addr_q;

  always_comb begin
    base_hi_d  = base_hi_q;
    first_d    = first_q;
    wcnt_d     = wcnt_q;
    lcnt_d     = lcnt_q;
    mem_addr_d = mem_addr_q;
    if (start_i) begin
      base_hi_d  = addr_i[ADDR_WIDTH-1:OffW];
      first_d    = wrap_i ? addr_i[OffW-1:2] : '0;
      wcnt_d     = '0;
      lcnt_d     = '0;
      mem_addr_d = {addr_i[ADDR_WIDTH-1:OffW], first_d, 2'b00};
    end else if (active_i) begin
      if (slot_last_o) begin
        lcnt_d = '0;
        wcnt_d = wcnt_q + WidxW'(1);
        // The address holds on the last word so IDLE/DONE keep showing it.
        if (!burst_last_o) begin
          mem_addr_d = {base_hi_q, widx_next, 2'b00};
        end
      end else begin
        lcnt_d = lcnt_q + LatW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      base_hi_q  <= '0;
      first_q    <= '0;
      wcnt_q     <= '0;
      lcnt_q     <= '0;
      mem_addr_q <= '0;
    end else begin
      base_hi_q  <= base_hi_d;
      first_q    <= first_d;
      wcnt_q     <= wcnt_d;
      lcnt_q     <= lcnt_d;
      mem_addr_q <= mem_addr_d;
    end
  end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Block burst sequencer between cache miss/eviction logic and external memory.
// Define MEM_BURST_CTRL_WRAP_EN for critical-word-first refills (writes stay linear).
module mem_burst_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned BLOCK_WORDS = DefBlockWords,
  parameter int unsigned MEM_LATENCY = DefMemLatency
) (
  input  logic                              clk,
  input  logic                              arst,
  input  logic                              i_start_read,
  input  logic                              i_start_write,
  input  logic                              i_access,
  input  logic [ADDR_WIDTH-1:0]             i_addr,
  input  logic [DATA_WIDTH*BLOCK_WORDS-1:0] i_wb_data,
  output logic [DATA_WIDTH*BLOCK_WORDS-1:0] o_block_data,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_mem_write_en,
  output logic                              o_mem_access,
  output logic [ADDR_WIDTH-1:0]             o_mem_addr,
  output logic [DATA_WIDTH-1:0]             o_mem_data,
  input  logic [DATA_WIDTH-1:0]             i_mem_data
);

  localparam int unsigned WidxW  = $clog2(BLOCK_WORDS);
  localparam int unsigned BlockW = DATA_WIDTH * BLOCK_WORDS;

  state_e                state_q, state_d;
  op_e                   op_q, op_d, start_op;
  logic                  access_q, access_d;
  logic [BlockW-1:0]     wb_q, wb_d;
  logic [BlockW-1:0]     block_q, block_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [WidxW-1:0]      widx, widx_next;
  logic                  start, active, wrap, slot_last, burst_last;

  assign active    = (state_q == StXfer);
  assign widx_next = widx + WidxW'(1);

`ifdef MEM_BURST_CTRL_WRAP_EN
  assign wrap = (start_op == OpRead);
`else
  assign wrap = 1'b0;
`endif

  burst_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BLOCK_WORDS (BLOCK_WORDS),
    .MEM_LATENCY (MEM_LATENCY)
  ) u_addr_gen (
    .clk          (clk),
    .arst         (arst),
    .start_i      (start),
    .wrap_i       (wrap),
    .active_i     (active),
    .addr_i       (i_addr),
    .mem_addr_o   (o_mem_addr),
    .widx_o       (widx),
    .slot_last_o  (slot_last),
    .burst_last_o (burst_last)
  );

  // Write wins when both requests arrive together; the dropped read is re-issued upstream.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    start_op = OpRead;
    case (state_q)
      StIdle: begin
        if (i_start_write || i_start_read) begin
          start    = 1'b1;
          start_op = i_start_write ? OpWrite : OpRead;
          state_d  = StXfer;
        end
      end
      StXfer: begin
        if (burst_last) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    access_d   = access_q;
    wb_d       = wb_q;
    block_d    = block_q;
    mem_data_d = mem_data_q;
    if (start) begin
      op_d     = start_op;
      access_d = i_access;
      wb_d     = i_wb_data;
      if (start_op == OpWrite) begin
        mem_data_d = i_wb_data[DATA_WIDTH-1:0];
      end
    end else if (slot_last) begin
      if (op_q == OpRead) begin
        block_d[int'(widx)*DATA_WIDTH +: DATA_WIDTH] = i_mem_data;
      end else if (!burst_last) begin
        mem_data_d = wb_q[int'(widx_next)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= StIdle;
      op_q       <= OpRead;
      access_q   <= 1'b0;
      wb_q       <= '0;
      block_q    <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      access_q   <= access_d;
      wb_q       <= wb_d;
      block_q    <= block_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign o_busy         = (state_q != StIdle);
  assign o_done         = (state_q == StDone);
  assign o_mem_write_en = active && (op_q == OpWrite) && slot_last;
  assign o_mem_access   = access_q;
  assign o_mem_data     = mem_data_q;
  assign o_block_data   = block_q;

endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Burst sequencer between the cache-side miss/eviction logic and the simulated external memory. On request it moves one whole cache block, BLOCK_WORDS words, one word at a time over the single-word memory port. Reads are refills and writes are write-backs. Each word slot is held for MEM_LATENCY cycles to model slow external memory. It then returns the assembled block with a one-cycle done pulse.

## Interface
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 64, byte address width
- BLOCK_WORDS, 16, words per block; power of two, ≥2
- MEM_LATENCY, 2, cycles per word slot; ≥1
- clk  in  1  clock; all logic on rising edge
- arst  in  1  asynchronous reset, active-high (one clock; reset is asynchronous and active-high)
- i_start_read  in  1  refill request, sampled in IDLE only
- i_start_write  in  1  write-back request, sampled in IDLE only
- i_access  in  1  0 = instruction memory, 1 = data memory; latched at start
- i_addr  in  ADDR_WIDTH  any byte address inside the target block; latched at start
- i_wb_data  in  DATA_WIDTH*BLOCK_WORDS  write-back block; word w at bits [w*DATA_WIDTH +: DATA_WIDTH]; latched at start
- o_block_data  out  DATA_WIDTH*BLOCK_WORDS  refilled block, same packing
- o_busy  out  1  state ≠ IDLE
- o_done  out  1  one-cycle completion pulse
- o_mem_write_en  out  1  memory write strobe
- o_mem_access  out  1  latched i_access
- o_mem_addr  out  ADDR_WIDTH  current word byte address
- o_mem_data  out  DATA_WIDTH  current write word
- i_mem_data  in  DATA_WIDTH  combinational read data from memory

## Operation
- FSM states: IDLE, XFER, DONE.
  - IDLE→XFER on either start.
  - XFER→DONE after the last word slot.
  - DONE→IDLE unconditionally.
- Start priority: if both starts are high, the write wins and the read is dropped. The requester re-issues it. Starts outside IDLE are ignored.
- At start, latch:
  - base = i_addr with the low log2(BLOCK_WORDS)+2 bits cleared
  - op, access, and i_wb_data
- Counters:
  - word counter wcnt, log2(BLOCK_WORDS) bits
  - slot counter lcnt, 0..MEM_LATENCY-1
- o_mem_addr = base + (widx << 2), where widx = wcnt (linear order).
- Write: o_mem_data = latched word widx. o_mem_write_en is high only in the last cycle of each slot (lcnt == MEM_LATENCY-1), so each word is written exactly once.
- Read: in the last cycle of each slot, i_mem_data is registered into o_block_data word widx. o_mem_write_en stays 0.
- o_block_data is updated only by reads. It holds its value otherwise and is stable from o_done until the next read start.
- Last slot: wcnt == BLOCK_WORDS-1 and lcnt == MEM_LATENCY-1 → DONE. wcnt wraps to 0.
- Reset, including mid-burst:
  - all outputs 0, state IDLE
  - no o_done pulse; a partial refill is discarded (o_block_data cleared)
  - writes already issued stay in memory

## Timing
- Start sampled at edge k: XFER runs from cycle k+1 to k+BLOCK_WORDS*MEM_LATENCY.
- o_done is high for exactly the cycle k+1+BLOCK_WORDS*MEM_LATENCY. With defaults, done is in cycle k+33.
- The earliest next start is sampled at the edge ending the DONE cycle's following IDLE cycle. Back-to-back spacing is BLOCK_WORDS*MEM_LATENCY+2 cycles.
- o_mem_addr, o_mem_access and o_mem_data are registered and stable for the whole slot. In IDLE/DONE they hold their last values; o_mem_write_en is 0.

## Configuration
- MEM_BURST_CTRL_WRAP_EN defined: reads are critical-word-first.
  - Start word s = i_addr[log2(BLOCK_WORDS)+1:2].
  - widx = (s + wcnt) mod BLOCK_WORDS, so the burst wraps past the block end.
  - Writes stay linear.
- Undefined: all bursts are linear from word 0.
- Packing of o_block_data is identical in both cases.

## Structure
- Package mem_ctrl_pkg: state enum (IDLE/XFER/DONE), op enum (OP_READ/OP_WRITE), default width constants.
- Sub-module burst_addr_gen: base latch, wcnt, lcnt and widx/wrap computation. Outputs o_mem_addr, widx, slot_last and burst_last.

## Test plan
- Reset with arst=1 → all outputs 0, o_busy=0; release and idle for 5 cycles → no memory write.
- Read, i_addr=0x104, access=1, memory word n = 0xA000+n → o_done in cycle k+33, o_block_data word n = 0xA000+n, addresses 0x100..0x13C in order (wrap disabled).
- Write, i_addr=0x200, word n = 0xB0+n → exactly 16 write strobes, each on the second slot cycle; mem[0x200+4n]=0xB0+n; o_block_data unchanged.
- Both starts high in IDLE → only the write burst runs; a start asserted mid-burst is ignored.
- arst pulsed at cycle k+10 of a read → outputs 0 and IDLE next cycle, no o_done; a new read then completes correctly.
- With MEM_BURST_CTRL_WRAP_EN, read i_addr=0x138 (s=14) → address order 0x138, 0x13C, 0x100, …, 0x134; final block packed identically to the linear case.
